// File: rtl/hbus_mi_bist_pkg.sv
// Shared types and constants for the hbus mi BIST initiator: FSM states, mode codes,
// mi_rw encodings and the LFSR polynomial/default seed.
package hbus_mi_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_DATA,
        ST_RD_SETUP,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_DONE
    } bist_state_t;

    localparam logic [1:0]  MODE_WR_RD        = 2'd0;
    localparam logic [1:0]  MODE_WR_ONLY      = 2'd1;
    localparam logic [1:0]  MODE_RD_ONLY      = 2'd2;

    localparam logic        MI_RW_WRITE       = 1'b0;
    localparam logic        MI_RW_READ        = 1'b1;
    localparam logic [1:0]  MI_ADDR_CS        = 2'b01;

    // Galois form of x^32 + x^22 + x^2 + x + 1, shifting right.
    localparam logic [31:0] LFSR_POLY         = 32'h8020_0003;
    localparam logic [31:0] LFSR_DEFAULT_SEED = 32'h0000_0001;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/hbus_mi_bist_lfsr.sv
// 32-bit Galois LFSR for BIST data: seed load (zero seed replaced by the default seed),
// single-step enable, state output.
module hbus_mi_bist_lfsr
    import hbus_mi_bist_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [31:0] seed_i,
    input  logic        step_i,
    output logic [31:0] state_o
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = (seed_i == 32'h0) ? LFSR_DEFAULT_SEED : seed_i;
        end else if (step_i) begin
            state_d = lfsr_step(state_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/hbus_mi_bist.sv
// BIST initiator on the hbus_memctrl mi_* port: writes LFSR bursts, re-reads and counts mismatching beats.
// Define HBUS_MI_BIST_ERRLOG_EN to add first-mismatch capture outputs ctl_err_addr/exp/got.
//   state    | meaning
//   IDLE     | waiting for ctl_start
//   WR_REQ   | write request on mi, held until mi_ready
//   WR_DATA  | supplying write beats until wack&wlast
//   RD_SETUP | rewind LFSR to seed and address to base
//   RD_REQ   | read request on mi, held until mi_ready
//   RD_DATA  | checking read beats until rstb&rlast
//   DONE     | one-cycle run end, raises ctl_done
module hbus_mi_bist
    import hbus_mi_bist_pkg::*;
#(
    parameter int ECNT_W = 16,
    parameter int NB_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ctl_start_i,
    input  logic [1:0]        ctl_mode_i,
    input  logic [31:0]       ctl_base_i,
    input  logic [6:0]        ctl_len_i,
    input  logic [NB_W-1:0]   ctl_nburst_i,
    input  logic [31:0]       ctl_seed_i,
    output logic              ctl_busy_o,
    output logic              ctl_done_o,
    output logic [ECNT_W-1:0] ctl_ecnt_o,
`ifdef HBUS_MI_BIST_ERRLOG_EN
    output logic [31:0]       ctl_err_addr_o,
    output logic [31:0]       ctl_err_exp_o,
    output logic [31:0]       ctl_err_got_o,
`endif
    output logic [1:0]        mi_addr_cs_o,
    output logic [31:0]       mi_addr_o,
    output logic [6:0]        mi_len_o,
    output logic              mi_rw_o,
    output logic              mi_linear_o,
    output logic              mi_valid_o,
    input  logic              mi_ready_i,
    output logic [31:0]       mi_wdata_o,
    output logic [3:0]        mi_wmsk_o,
    input  logic              mi_wack_i,
    input  logic              mi_wlast_i,
    input  logic [31:0]       mi_rdata_i,
    input  logic              mi_rstb_i,
    input  logic              mi_rlast_i
);

    bist_state_t       state_q, state_d;
    logic              busy_q, done_q, wr_only_q;
    logic [ECNT_W-1:0] ecnt_q;
    logic [31:0]       addr_q, base_q, seed_q;
    logic [6:0]        len_q;
    logic [NB_W-1:0]   nb_q, cnt_q;

    logic              start_ok, wr_beat, rd_beat, wr_end, rd_end, last_burst, mismatch;
    logic              lfsr_load;
    logic [31:0]       lfsr_seed, lfsr_q;

    assign start_ok   = (state_q == ST_IDLE) && ctl_start_i;
    assign wr_end     = wr_beat && mi_wlast_i;
    assign rd_end     = rd_beat && mi_rlast_i;
    assign last_burst = (cnt_q == NB_W'(1));
    assign mismatch   = (mi_rdata_i != lfsr_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ctl_start_i) begin
                    if (ctl_nburst_i == '0) begin
                        state_d = ST_DONE;
                    end else if (ctl_mode_i == MODE_RD_ONLY) begin
                        state_d = ST_RD_REQ;
                    end else begin
                        state_d = ST_WR_REQ;
                    end
                end
            end
            ST_WR_REQ:   if (mi_ready_i) state_d = ST_WR_DATA;
            ST_WR_DATA: begin
                if (wr_end) begin
                    if (!last_burst) begin
                        state_d = ST_WR_REQ;
                    end else if (wr_only_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RD_SETUP;
                    end
                end
            end
            ST_RD_SETUP: state_d = ST_RD_REQ;
            ST_RD_REQ:   if (mi_ready_i) state_d = ST_RD_DATA;
            ST_RD_DATA:  if (rd_end) state_d = last_burst ? ST_DONE : ST_RD_REQ;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mi_valid_o = 1'b0;
        mi_rw_o    = MI_RW_WRITE;
        wr_beat    = 1'b0;
        rd_beat    = 1'b0;
        case (state_q)
            ST_WR_REQ:  mi_valid_o = 1'b1;
            ST_RD_REQ: begin
                mi_valid_o = 1'b1;
                mi_rw_o    = MI_RW_READ;
            end
            ST_WR_DATA: wr_beat = mi_wack_i;
            ST_RD_DATA: rd_beat = mi_rstb_i;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_only_q <= 1'b0;
            ecnt_q    <= '0;
            addr_q    <= '0;
            base_q    <= '0;
            seed_q    <= '0;
            len_q     <= '0;
            nb_q      <= '0;
            cnt_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (start_ok) begin
                busy_q    <= 1'b1;
                wr_only_q <= (ctl_mode_i == MODE_WR_ONLY);
                ecnt_q    <= '0;
                addr_q    <= ctl_base_i;
                base_q    <= ctl_base_i;
                seed_q    <= ctl_seed_i;
                len_q     <= ctl_len_i;
                nb_q      <= ctl_nburst_i;
                cnt_q     <= ctl_nburst_i;
            end
            if (state_q == ST_RD_SETUP) begin
                addr_q <= base_q;
                cnt_q  <= nb_q;
            end
            if (state_q == ST_DONE) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
            if (wr_end || rd_end) begin
                addr_q <= addr_q + {25'd0, len_q} + 32'd1;
                cnt_q  <= cnt_q - 1'b1;
            end
            if (rd_beat && mismatch && (ecnt_q != {ECNT_W{1'b1}})) begin
                ecnt_q <= ecnt_q + 1'b1;
            end
        end
    end

    // Write phase starts from the freshly loaded seed; read phase rewinds to the same seed.
    assign lfsr_load = start_ok || (state_q == ST_RD_SETUP);
    assign lfsr_seed = start_ok ? ctl_seed_i : seed_q;

    hbus_mi_bist_lfsr u_lfsr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (lfsr_load),
        .seed_i  (lfsr_seed),
        .step_i  (wr_beat || rd_beat),
        .state_o (lfsr_q)
    );

`ifdef HBUS_MI_BIST_ERRLOG_EN
    logic [6:0]  beat_q;
    logic        err_seen_q;
    logic [31:0] err_addr_q, err_exp_q, err_got_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_q     <= '0;
            err_seen_q <= 1'b0;
            err_addr_q <= '0;
            err_exp_q  <= '0;
            err_got_q  <= '0;
        end else begin
            if (mi_valid_o && mi_ready_i) begin
                beat_q <= '0;
            end else if (rd_beat) begin
                beat_q <= beat_q + 1'b1;
            end
            if (start_ok) begin
                err_seen_q <= 1'b0;
                err_addr_q <= '0;
                err_exp_q  <= '0;
                err_got_q  <= '0;
            end else if (rd_beat && mismatch && !err_seen_q) begin
                err_seen_q <= 1'b1;
                err_addr_q <= addr_q + {25'd0, beat_q};
                err_exp_q  <= lfsr_q;
                err_got_q  <= mi_rdata_i;
            end
        end
    end

    assign ctl_err_addr_o = err_addr_q;
    assign ctl_err_exp_o  = err_exp_q;
    assign ctl_err_got_o  = err_got_q;
`endif

    assign ctl_busy_o   = busy_q;
    assign ctl_done_o   = done_q;
    assign ctl_ecnt_o   = ecnt_q;
    assign mi_addr_cs_o = MI_ADDR_CS;
    assign mi_addr_o    = addr_q;
    assign mi_len_o     = len_q;
    assign mi_linear_o  = 1'b0;
    assign mi_wdata_o   = lfsr_q;
    assign mi_wmsk_o    = 4'h0;

endmodule

// File: tb/tb_hbus_mi_bist.sv
// Randomized bench for hbus_mi_bist: memory-slave stub on the mi port plus a run-level reference model.
// Covers HBUS_MI_BIST_ERRLOG_EN outputs when the macro is defined.
module tb_hbus_mi_bist;

    localparam int ECNT_W = 16;
    localparam int NB_W   = 16;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              ctl_start_i = 1'b0;
    logic [1:0]        ctl_mode_i = '0;
    logic [31:0]       ctl_base_i = '0;
    logic [6:0]        ctl_len_i = '0;
    logic [NB_W-1:0]   ctl_nburst_i = '0;
    logic [31:0]       ctl_seed_i = '0;
    logic              ctl_busy_o, ctl_done_o;
    logic [ECNT_W-1:0] ctl_ecnt_o;
`ifdef HBUS_MI_BIST_ERRLOG_EN
    logic [31:0]       ctl_err_addr_o, ctl_err_exp_o, ctl_err_got_o;
`endif
    logic [1:0]        mi_addr_cs_o;
    logic [31:0]       mi_addr_o;
    logic [6:0]        mi_len_o;
    logic              mi_rw_o, mi_linear_o, mi_valid_o;
    logic              mi_ready_i = 1'b0;
    logic [31:0]       mi_wdata_o;
    logic [3:0]        mi_wmsk_o;
    logic              mi_wack_i = 1'b0, mi_wlast_i = 1'b0;
    logic [31:0]       mi_rdata_i = '0;
    logic              mi_rstb_i = 1'b0, mi_rlast_i = 1'b0;

    always #5 clk_i = ~clk_i;

    hbus_mi_bist #(.ECNT_W(ECNT_W), .NB_W(NB_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ctl_start_i(ctl_start_i), .ctl_mode_i(ctl_mode_i), .ctl_base_i(ctl_base_i),
        .ctl_len_i(ctl_len_i), .ctl_nburst_i(ctl_nburst_i), .ctl_seed_i(ctl_seed_i),
        .ctl_busy_o(ctl_busy_o), .ctl_done_o(ctl_done_o), .ctl_ecnt_o(ctl_ecnt_o),
`ifdef HBUS_MI_BIST_ERRLOG_EN
        .ctl_err_addr_o(ctl_err_addr_o), .ctl_err_exp_o(ctl_err_exp_o), .ctl_err_got_o(ctl_err_got_o),
`endif
        .mi_addr_cs_o(mi_addr_cs_o), .mi_addr_o(mi_addr_o), .mi_len_o(mi_len_o),
        .mi_rw_o(mi_rw_o), .mi_linear_o(mi_linear_o), .mi_valid_o(mi_valid_o),
        .mi_ready_i(mi_ready_i), .mi_wdata_o(mi_wdata_o), .mi_wmsk_o(mi_wmsk_o),
        .mi_wack_i(mi_wack_i), .mi_wlast_i(mi_wlast_i), .mi_rdata_i(mi_rdata_i),
        .mi_rstb_i(mi_rstb_i), .mi_rlast_i(mi_rlast_i)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [31:0] fill(input logic [31:0] a);
        return a ^ 32'hC3A5_0F96;
    endfunction

    // Slave-side state and logs (written only by the slave process)
    logic [31:0] mem [logic [31:0]];
    logic [31:0] req_addr_q[$];
    logic        req_rw_q[$];
    logic [6:0]  req_len_q[$];
    logic [31:0] wdat_q[$];
    logic [31:0] rgot_q[$];
    int          rd_count = 0;
    int          done_cnt = 0;
    int          valid_cnt = 0;

    // Stimulus knobs (written only by the main process)
    int force_wait  = 0;
    int corrupt_pct = 0;
    int corrupt_idx = -1;

    always @(negedge clk_i) begin
        if (ctl_done_o) done_cnt++;
        if (mi_valid_o) valid_cnt++;
    end

    initial begin : slave
        int          s_left, s_beat, s_wait;
        logic        s_pend, s_rw, s_req_rw;
        logic [31:0] s_addr, s_req_addr, a, d;
        s_left = 0; s_beat = 0; s_wait = 0; s_pend = 1'b0;
        s_rw = 1'b0; s_req_rw = 1'b0; s_addr = '0; s_req_addr = '0;
        forever begin
            @(posedge clk_i); #1;
            mi_ready_i = 1'b0; mi_wack_i = 1'b0; mi_wlast_i = 1'b0;
            mi_rstb_i  = 1'b0; mi_rlast_i = 1'b0;
            if (rst_i) begin
                s_left = 0;
                s_pend = 1'b0;
            end else if (s_left > 0) begin
                if ($urandom_range(3) != 0) begin
                    a = s_addr + 32'(s_beat);
                    if (!s_rw) begin
                        mi_wack_i  = 1'b1;
                        mi_wlast_i = (s_left == 1);
                        mem[a] = mi_wdata_o;
                        wdat_q.push_back(mi_wdata_o);
                    end else begin
                        d = mem.exists(a) ? mem[a] : fill(a);
                        if ((corrupt_pct > 0 && $urandom_range(99) < corrupt_pct) || rd_count == corrupt_idx)
                            d = d ^ 32'h0000_0100;
                        mi_rdata_i = d;
                        mi_rstb_i  = 1'b1;
                        mi_rlast_i = (s_left == 1);
                        rgot_q.push_back(d);
                        rd_count++;
                    end
                    s_beat++;
                    s_left--;
                end
            end else if (mi_valid_o) begin
                if (!s_pend) begin
                    s_pend = 1'b1;
                    s_req_addr = mi_addr_o;
                    s_req_rw = mi_rw_o;
                    s_wait = (force_wait > 0) ? force_wait : int'($urandom_range(2));
                end else begin
                    chk("req_stable_addr", mi_addr_o, s_req_addr);
                    chk("req_stable_rw", mi_rw_o, s_req_rw);
                end
                if (s_wait == 0) begin
                    mi_ready_i = 1'b1;
                    s_pend = 1'b0;
                    req_addr_q.push_back(mi_addr_o);
                    req_rw_q.push_back(mi_rw_o);
                    req_len_q.push_back(mi_len_o);
                    s_addr = mi_addr_o;
                    s_rw = mi_rw_o;
                    s_left = int'(mi_len_o) + 1;
                    s_beat = 0;
                end else begin
                    s_wait--;
                end
            end else if ($urandom_range(7) == 0) begin
                // stray handshakes outside any data phase must be ignored
                mi_wack_i = 1'b1; mi_wlast_i = 1'b1;
                mi_rstb_i = 1'b1; mi_rlast_i = 1'b1;
                mi_rdata_i = $urandom;
            end
        end
    end

    task automatic run_bist(input logic [1:0] mode, input logic [31:0] base, input logic [6:0] len,
                            input logic [NB_W-1:0] nb, input logic [31:0] seed, input int pct,
                            input int cidx, input int exp_ecnt, input int exp_vcyc);
        int          r0, w0, g0, d0, v0, cyc, n_req, n_w, n_r, errs, bl;
        logic        do_wr, do_rd, rd_ph;
        logic [31:0] s, exp_a, f_addr, f_exp, f_got;
        r0 = req_addr_q.size(); w0 = wdat_q.size(); g0 = rgot_q.size();
        d0 = done_cnt; v0 = valid_cnt;
        corrupt_pct = pct;
        corrupt_idx = (cidx < 0) ? -1 : rd_count + cidx;
        ctl_mode_i = mode; ctl_base_i = base; ctl_len_i = len;
        ctl_nburst_i = nb; ctl_seed_i = seed; ctl_start_i = 1'b1;
        @(posedge clk_i); #1;
        ctl_start_i = 1'b0;
        cyc = 1;
        chk("busy_after_start", ctl_busy_o, 1);
        while (!ctl_done_o && cyc < 3000) begin
            @(posedge clk_i); #1;
            cyc++;
        end
        chk("done_seen", ctl_done_o, 1);
        if (nb == 0) chk("empty_done_latency", cyc, 2);
        chk("busy_at_done", ctl_busy_o, 0);
        @(posedge clk_i); #1;
        chk("done_pulse_width", ctl_done_o, 0);
        chk("done_pulses", done_cnt - d0, 1);
        if (exp_vcyc >= 0) chk("valid_cycles", valid_cnt - v0, exp_vcyc);

        // Reference: mode 3 behaves as mode 0; requests at base + b*(len+1)
        do_wr = (mode != 2'd2);
        do_rd = (mode != 2'd1);
        bl    = int'(len) + 1;
        n_req = int'(nb) * (int'(do_wr) + int'(do_rd));
        chk("req_count", req_addr_q.size() - r0, n_req);
        for (int i = 0; i < n_req && r0 + i < req_addr_q.size(); i++) begin
            rd_ph = !do_wr || (i >= int'(nb));
            exp_a = base + 32'((rd_ph && do_wr) ? i - int'(nb) : i) * 32'(bl);
            chk("req_addr", req_addr_q[r0 + i], exp_a);
            chk("req_rw", req_rw_q[r0 + i], rd_ph);
            chk("req_len", req_len_q[r0 + i], len);
        end

        n_w = do_wr ? int'(nb) * bl : 0;
        chk("wr_beats", wdat_q.size() - w0, n_w);
        s = (seed == 0) ? 32'h1 : seed;
        for (int i = 0; i < n_w && w0 + i < wdat_q.size(); i++) begin
            chk("wdata", wdat_q[w0 + i], s);
            s = lfsr_next(s);
        end

        n_r = do_rd ? int'(nb) * bl : 0;
        chk("rd_beats", rgot_q.size() - g0, n_r);
        s = (seed == 0) ? 32'h1 : seed;
        errs = 0; f_addr = '0; f_exp = '0; f_got = '0;
        for (int i = 0; i < rgot_q.size() - g0; i++) begin
            if (rgot_q[g0 + i] != s) begin
                if (errs == 0) begin
                    f_addr = base + 32'(i / bl) * 32'(bl) + 32'(i % bl);
                    f_exp  = s;
                    f_got  = rgot_q[g0 + i];
                end
                errs++;
            end
            s = lfsr_next(s);
        end
        chk("ecnt", ctl_ecnt_o, (errs > 65535) ? 65535 : errs);
        if (exp_ecnt >= 0) chk("ecnt_directed", ctl_ecnt_o, exp_ecnt);
`ifdef HBUS_MI_BIST_ERRLOG_EN
        chk("err_addr", ctl_err_addr_o, f_addr);
        chk("err_exp", ctl_err_exp_o, f_exp);
        chk("err_got", ctl_err_got_o, f_got);
`endif
        corrupt_pct = 0;
        corrupt_idx = -1;
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: time limit reached, required run completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int          cyc, rc0;
        logic [1:0]  m;
        logic [6:0]  l;
        logic [31:0] b;
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_valid", mi_valid_o, 0);
        chk("rst_busy", ctl_busy_o, 0);
        chk("rst_done", ctl_done_o, 0);
        chk("rst_ecnt", ctl_ecnt_o, 0);
        chk("rst_addr", mi_addr_o, 0);
        chk("rst_rw", mi_rw_o, 0);
        chk("rst_wdata", mi_wdata_o, 0);
        chk("addr_cs", mi_addr_cs_o, 2'b01);
        chk("linear", mi_linear_o, 0);
        chk("wmsk", mi_wmsk_o, 0);
`ifdef HBUS_MI_BIST_ERRLOG_EN
        chk("rst_err_addr", ctl_err_addr_o, 0);
`endif
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        run_bist(2'd0, 32'h0000_2000, 7'd31, 16'd4, 32'h0000_ACE1, 0, -1, 0, -1);
        run_bist(2'd1, 32'h0010_0000, 7'd31, 16'd1, 32'h1, 0, -1, -1, -1);
        run_bist(2'd2, 32'h0010_0000, 7'd31, 16'd1, 32'h2, 0, -1, 32, -1);
        run_bist(2'd0, 32'h0000_4000, 7'd3, 16'd0, 32'h55, 0, -1, 0, 0);
        force_wait = 10;
        run_bist(2'd1, 32'h0000_0300, 7'd3, 16'd1, 32'h77, 0, -1, -1, 11);
        force_wait = 0;
        run_bist(2'd0, 32'h0, 7'd7, 16'd3, 32'hBEEF_0001, 0, 21, 1, -1);

        // Abort mid read phase with every read beat corrupted
        corrupt_pct = 100;
        rc0 = rd_count;
        ctl_mode_i = 2'd0; ctl_base_i = 32'h5000; ctl_len_i = 7'd15;
        ctl_nburst_i = 16'd2; ctl_seed_i = 32'h1234_5678; ctl_start_i = 1'b1;
        @(posedge clk_i); #1;
        ctl_start_i = 1'b0;
        cyc = 0;
        while (rd_count < rc0 + 5 && cyc < 3000) begin
            @(posedge clk_i); #1;
            cyc++;
        end
        chk("abort_reached_rd", rd_count >= rc0 + 5, 1);
        chk("abort_ecnt_nonzero", ctl_ecnt_o != 0, 1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        chk("abort_valid", mi_valid_o, 0);
        chk("abort_busy", ctl_busy_o, 0);
        chk("abort_ecnt", ctl_ecnt_o, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        corrupt_pct = 0;
        @(posedge clk_i); #1;
        run_bist(2'd0, 32'h5000, 7'd15, 16'd2, 32'h1234_5678, 0, -1, 0, -1);

        for (int k = 0; k < 12; k++) begin
            m = 2'($urandom_range(3));
            l = ($urandom_range(3) == 0) ? 7'($urandom_range(127, 32)) : 7'($urandom_range(15));
            b = ($urandom_range(1) == 0) ? $urandom : 32'hFFFF_FFF0 + 32'($urandom_range(15));
            run_bist(m, b, l, 16'($urandom_range(3)),
                     ($urandom_range(4) == 0) ? 32'h0 : $urandom,
                     ($urandom_range(1) == 0) ? 0 : 15, -1, -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
